// File: rtl/esl_nios_ii_system_cpu_debug_action_sched.sv
// Debug action scheduler: queues strobes, issues one at a time; strobe-to-cmd_valid 2 cycles.
// Backpressure: cmd_valid holds until cmd_ready or ACK_TIMEOUT; full FIFO drops strobes and flags overflow.
module esl_nios_ii_system_cpu_debug_action_sched #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  act_strobe,
    input  logic [37:0] jdo,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic [37:0] cmd_data,
    input  logic        cmd_ready,
    output logic        busy,
    output logic [2:0]  status,
    input  logic        clr_status,
    output logic [4:0]  level
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [40:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [4:0]    r_level;
    logic [7:0]    r_cnt;
    logic [2:0]    r_pop_code;
    logic [37:0]   r_pop_data;
    logic          r_cmd_valid;
    logic [2:0]    r_cmd_code;
    logic [37:0]   r_cmd_data;
    logic [2:0]    r_status;

    logic [2:0]    w_code;
    logic          w_strobe;
    logic          w_multi;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_load;
    logic          w_done;
    logic          w_abort;

    // Lowest set strobe bit wins; higher bits in the same cycle are only reported.
    always_comb begin
        w_code = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (act_strobe[i]) w_code = 3'(i);
        end
    end

    assign w_strobe = |act_strobe;
    assign w_multi  = |(act_strobe & (act_strobe - 6'd1));
    assign w_full   = (r_level == 5'(DEPTH));
    assign w_empty  = (r_level == 5'd0);
    assign w_push   = w_strobe && (!w_full || w_pop);
    assign w_drop   = w_strobe && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_load  = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load = 1'b1;
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cmd_ready) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end else if (r_cnt == 8'(ACK_TIMEOUT)) begin
                    w_abort = 1'b1;
                    w_next  = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) r_mem[r_wr_ptr] <= {w_code, jdo};
    end

    // The popped entry is latched because a same-cycle push into a full FIFO reuses its slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= 5'd0;
            r_cnt       <= 8'd0;
            r_pop_code  <= 3'd0;
            r_pop_data  <= 38'd0;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= 3'd0;
            r_cmd_data  <= 38'd0;
            r_status    <= 3'b000;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_pop_code <= r_mem[r_rd_ptr][40:38];
                r_pop_data <= r_mem[r_rd_ptr][37:0];
            end
            if (w_push && !w_pop)      r_level <= r_level + 5'd1;
            else if (!w_push && w_pop) r_level <= r_level - 5'd1;

            if (w_load) begin
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= r_pop_code;
                r_cmd_data  <= r_pop_data;
                r_cnt       <= 8'd0;
            end else if (w_done || w_abort) begin
                r_cmd_valid <= 1'b0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end

            r_status <= (clr_status ? 3'b000 : r_status)
                      | {w_abort, w_strobe && w_multi, w_drop};
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign cmd_data  = r_cmd_data;
    assign status    = r_status;
    assign level     = r_level;
    assign busy      = (r_state != ST_IDLE) || !w_empty;
endmodule

// File: tb/tb_esl_nios_ii_system_cpu_debug_action_sched.sv
// Directed bench for the debug action scheduler (DEPTH=4, ACK_TIMEOUT=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_esl_nios_ii_system_cpu_debug_action_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  act_strobe;
    logic [37:0] jdo;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [37:0] cmd_data;
    logic        cmd_ready;
    logic        busy;
    logic [2:0]  status;
    logic        clr_status;
    logic [4:0]  level;

    int errors = 0;
    int checks = 0;
    int high_cnt;
    int guard;

    always #5 clk = ~clk;

    esl_nios_ii_system_cpu_debug_action_sched #(
        .DEPTH       (4),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .act_strobe (act_strobe),
        .jdo        (jdo),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .status     (status),
        .clr_status (clr_status),
        .level      (level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        act_strobe = 6'd0;
        jdo        = 38'd0;
        cmd_ready  = 1'b0;
        clr_status = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", cmd_valid, 0);
        chk("rst_code", cmd_code, 0);
        chk("rst_data", cmd_data, 0);
        chk("rst_level", level, 0);
        chk("rst_status", status, 0);
        chk("rst_busy", busy, 0);

        // Single action: enqueue at N, valid at N+2, complete on ready.
        act_strobe = 6'b000100;
        jdo        = 38'h1_2345_6789;
        tick();
        act_strobe = 6'd0;
        jdo        = 38'd0;
        chk("single_lvl_n", level, 1);
        chk("single_valid_n", cmd_valid, 0);
        chk("single_busy_n", busy, 1);
        tick();
        chk("single_lvl_n1", level, 0);
        chk("single_valid_n1", cmd_valid, 0);
        tick();
        chk("single_valid_n2", cmd_valid, 1);
        chk("single_code", cmd_code, 2);
        chk("single_data", cmd_data, 38'h1_2345_6789);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("single_valid_fall", cmd_valid, 0);
        chk("single_busy_end", busy, 0);
        chk("single_status", status, 0);

        // Multi-strobe: lowest bit enqueued, multi_err flagged, then cleared.
        act_strobe = 6'b100010;
        jdo        = 38'h0_AAAA_5555;
        tick();
        act_strobe = 6'd0;
        chk("multi_status", status, 3'b010);
        chk("multi_level", level, 1);
        tick();
        tick();
        chk("multi_valid", cmd_valid, 1);
        chk("multi_code", cmd_code, 1);
        chk("multi_data", cmd_data, 38'h0_AAAA_5555);
        cmd_ready = 1'b1;
        tick();
        cmd_ready  = 1'b0;
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("multi_clr", status, 0);
        chk("multi_busy", busy, 0);

        // Overflow: six strobes, first issues, four queue, sixth dropped.
        for (int k = 0; k < 6; k++) begin
            act_strobe = 6'(1 << k);
            jdo        = 38'(256 + k);
            tick();
        end
        act_strobe = 6'd0;
        jdo        = 38'd0;
        chk("ovf_level", level, 4);
        chk("ovf_status", status, 3'b001);
        chk("ovf_valid", cmd_valid, 1);
        chk("ovf_code", cmd_code, 0);
        chk("ovf_data", cmd_data, 38'h100);

        // Timeout: with no ready, cmd_valid stays high for 9 cycles in total.
        high_cnt = 4;
        guard    = 0;
        while (cmd_valid && guard < 30) begin
            tick();
            guard++;
            if (cmd_valid) high_cnt++;
        end
        chk("to_length", high_cnt, 9);
        chk("to_status", status, 3'b101);
        chk("to_level", level, 4);
        tick();
        chk("to_next_pop", level, 3);
        tick();
        chk("to_next_valid", cmd_valid, 1);
        chk("to_next_code", cmd_code, 1);
        chk("to_next_data", cmd_data, 38'h101);

        // Refill to 4 while the FSM returns to IDLE, then strobe on the pop cycle.
        cmd_ready  = 1'b1;
        clr_status = 1'b1;
        act_strobe = 6'b010000;
        jdo        = 38'h200;
        tick();
        cmd_ready  = 1'b0;
        clr_status = 1'b0;
        act_strobe = 6'b100000;
        jdo        = 38'h201;
        chk("full_level", level, 4);
        chk("full_valid", cmd_valid, 0);
        chk("full_status_clr", status, 0);
        tick();
        act_strobe = 6'd0;
        jdo        = 38'd0;
        chk("fullpop_level", level, 4);
        chk("fullpop_status", status, 0);

        // FIFO order continues with the remaining queued entries.
        tick();
        chk("ord2_valid", cmd_valid, 1);
        chk("ord2_code", cmd_code, 2);
        chk("ord2_data", cmd_data, 38'h102);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("ord2_fall", cmd_valid, 0);
        tick();
        chk("ord3_pop_level", level, 3);
        tick();
        chk("ord3_code", cmd_code, 3);
        chk("ord3_data", cmd_data, 38'h103);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        tick();
        tick();
        chk("ord4_valid", cmd_valid, 1);
        chk("ord4_code", cmd_code, 4);
        chk("ord4_data", cmd_data, 38'h104);
        chk("ord4_level", level, 2);

        // Reset in WAIT with a strobe during reset that must be ignored.
        reset      = 1'b1;
        act_strobe = 6'b000001;
        jdo        = 38'h3FF;
        tick();
        reset      = 1'b0;
        act_strobe = 6'd0;
        jdo        = 38'd0;
        chk("rw_valid", cmd_valid, 0);
        chk("rw_level", level, 0);
        chk("rw_status", status, 0);
        chk("rw_busy", busy, 0);
        chk("rw_code", cmd_code, 0);
        chk("rw_data", cmd_data, 0);
        tick();
        chk("rw_level_after", level, 0);
        chk("rw_valid_after", cmd_valid, 0);

        // A new error in the same cycle as clr_status keeps the flag set.
        clr_status = 1'b1;
        act_strobe = 6'b000011;
        jdo        = 38'h55;
        tick();
        clr_status = 1'b0;
        act_strobe = 6'd0;
        jdo        = 38'd0;
        chk("setwins_status", status, 3'b010);
        chk("setwins_level", level, 1);
        tick();
        tick();
        chk("setwins_valid", cmd_valid, 1);
        chk("setwins_code", cmd_code, 0);
        chk("setwins_data", cmd_data, 38'h55);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("final_valid", cmd_valid, 0);
        chk("final_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
